mips_hazard_unit: RTL and testbench

Parametrised hazard/control unit for the next-generation 5-stage MIPS pipeline. It centralises:
- forwarding selects
- load-use stall
- branch/jump flush, with a selectable branch-resolve stage
- multi-cycle execute handshake (mul/div) with timeout

It also keeps saturating performance counters. The unit holds no datapath registers; it drives only the enable, flush and select controls of the IF/ID, ID/EX and EX/MEM buffers and the PC.

---
 rtl/mips_pkg.sv | 19 +
 rtl/sat_counter.sv | 23 ++
 rtl/mips_hazard_unit.sv | 202 ++++++++++++++++++++
 tb/tb_mips_hazard_unit.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and types for the MIPS pipeline control slice.
// Holds forwarding select codes, multi-cycle FSM states and branch-stage ids.
package mips_pkg;

    // Forwarding mux selects for the EX-stage ALU operands
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    // Stage in which a branch is resolved
    localparam int BRANCH_EX  = 0;
    localparam int BRANCH_MEM = 1;

    typedef enum logic {
        MC_IDLE = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_e;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating event counter with synchronous clear.
// Ports: clk, reset (async, active-low), inc, clr (wins over inc), count.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mips_hazard_unit.sv
// mips_hazard_unit: forwarding, load-use stall, branch/jump flush and
// multi-cycle execute handshake for the 5-stage pipeline, plus perf counters.
// Inputs : clk, reset (async, active-low), ID/EX/MEM/WB register specifiers
//          and control bits, branch_taken, mc_done, perf_clr.
// Outputs: fwd_a/fwd_b selects, PC/IF-ID stall, ID-EX hold/bubble,
//          EX-MEM bubble, per-stage flushes, mc_start/mc_abort pulses,
//          sticky mc_timeout, and three saturating perf counters.
module mips_hazard_unit
    import mips_pkg::*;
#(
    parameter int REG_ADDR_W   = 5,
    parameter int BRANCH_STAGE = 1,
    parameter int MC_TIMEOUT   = 64,
    parameter int CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  id_jump,
    input  logic [REG_ADDR_W-1:0] ex_rs,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic [REG_ADDR_W-1:0] ex_wr_reg,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic                  ex_is_mc,
    input  logic [REG_ADDR_W-1:0] mem_wr_reg,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_wr_reg,
    input  logic                  wb_reg_write,
    input  logic                  branch_taken,
    input  logic                  mc_done,
    input  logic                  perf_clr,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  stall_pc,
    output logic                  stall_if_id,
    output logic                  hold_id_ex,
    output logic                  bubble_id_ex,
    output logic                  bubble_ex_mem,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic                  flush_ex_mem,
    output logic                  mc_start,
    output logic                  mc_abort,
    output logic                  mc_timeout,
    output logic [CNT_W-1:0]      perf_load_use,
    output logic [CNT_W-1:0]      perf_mc_stall,
    output logic [CNT_W-1:0]      perf_flush
);

    localparam int TW = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_MAX = TW'(MC_TIMEOUT - 1);
    localparam logic KILL_EX_MEM = (BRANCH_STAGE == BRANCH_MEM);

    mc_state_e     state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          set_to;
    logic          busy, lu, mc_wait, to_hit;
    logic          ev_lu, ev_mc, ev_fl;

    assign busy    = (state_q == MC_BUSY);
    assign mc_wait = ex_is_mc && !(busy && mc_done);
    assign to_hit  = busy && !mc_done && (tcnt_q == TO_MAX);

    assign lu = ex_mem_read && (ex_wr_reg != '0) &&
                ((id_uses_rs && (ex_wr_reg == id_rs)) ||
                 (id_uses_rt && (ex_wr_reg == id_rt)));

    // Operand forwarding: the younger producer in MEM beats WB
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (reset) begin
            if (mem_reg_write && (mem_wr_reg != '0) &&
                (mem_wr_reg == ex_rs)) begin
                fwd_a = FWD_MEM;
            end else if (wb_reg_write && (wb_wr_reg != '0) &&
                         (wb_wr_reg == ex_rs)) begin
                fwd_a = FWD_WB;
            end
            if (mem_reg_write && (mem_wr_reg != '0) &&
                (mem_wr_reg == ex_rt)) begin
                fwd_b = FWD_MEM;
            end else if (wb_reg_write && (wb_wr_reg != '0) &&
                         (wb_wr_reg == ex_rt)) begin
                fwd_b = FWD_WB;
            end
        end
    end

    // Control priority: branch kill > mc wait > load-use > jump.
    // Everything is held low while reset is asserted.
    always_comb begin
        state_d       = state_q;
        tcnt_d        = tcnt_q;
        set_to        = 1'b0;
        stall_pc      = 1'b0;
        stall_if_id   = 1'b0;
        hold_id_ex    = 1'b0;
        bubble_id_ex  = 1'b0;
        bubble_ex_mem = 1'b0;
        flush_if_id   = 1'b0;
        flush_id_ex   = 1'b0;
        flush_ex_mem  = 1'b0;
        mc_start      = 1'b0;
        mc_abort      = 1'b0;
        ev_lu         = 1'b0;
        ev_mc         = 1'b0;
        ev_fl         = 1'b0;
        if (reset) begin
            if (branch_taken) begin
                flush_if_id  = 1'b1;
                flush_id_ex  = 1'b1;
                flush_ex_mem = KILL_EX_MEM;
                ev_fl        = 1'b1;
                // A busy mc op is younger than a MEM-resolved branch
                if (busy && KILL_EX_MEM) begin
                    mc_abort = 1'b1;
                    state_d  = MC_IDLE;
                end
            end else begin
                if (busy) begin
                    tcnt_d = tcnt_q + TW'(1);
                    if (mc_done) begin
                        state_d = MC_IDLE;
                    end else if (to_hit) begin
                        mc_abort      = 1'b1;
                        set_to        = 1'b1;
                        bubble_ex_mem = 1'b1;
                        state_d       = MC_IDLE;
                    end
                end else if (ex_is_mc) begin
                    mc_start = 1'b1;
                    tcnt_d   = '0;
                    state_d  = MC_BUSY;
                end
                if (mc_wait) begin
                    // ID/EX is held, so the load-use bubble is suppressed
                    stall_pc      = 1'b1;
                    stall_if_id   = 1'b1;
                    hold_id_ex    = 1'b1;
                    bubble_ex_mem = 1'b1;
                    ev_mc         = 1'b1;
                end else if (lu) begin
                    stall_pc     = 1'b1;
                    stall_if_id  = 1'b1;
                    bubble_id_ex = 1'b1;
                    ev_lu        = 1'b1;
                end else if (id_jump) begin
                    flush_if_id = 1'b1;
                    ev_fl       = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= MC_IDLE;
            tcnt_q     <= '0;
            mc_timeout <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            if (set_to) begin
                mc_timeout <= 1'b1;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_cnt_lu (
        .clk   (clk),
        .reset (reset),
        .inc   (ev_lu),
        .clr   (perf_clr),
        .count (perf_load_use)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_mc (
        .clk   (clk),
        .reset (reset),
        .inc   (ev_mc),
        .clr   (perf_clr),
        .count (perf_mc_stall)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_fl (
        .clk   (clk),
        .reset (reset),
        .inc   (ev_fl),
        .clr   (perf_clr),
        .count (perf_flush)
    );

    // ex_reg_write is part of the EX bundle but does not affect any hazard
    logic unused_ok;
    assign unused_ok = ex_reg_write;

endmodule

// File: tb/tb_mips_hazard_unit.sv
// tb_mips_hazard_unit: directed bench with a cycle-level reference model.
// Instance uses BRANCH_STAGE=1, MC_TIMEOUT=8, CNT_W=4.
module tb_mips_hazard_unit;

    localparam int RW   = 5;
    localparam int BS   = 1;
    localparam int TO   = 8;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [RW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_wr_reg;
    logic [RW-1:0] mem_wr_reg, wb_wr_reg;
    logic          id_uses_rs, id_uses_rt, id_jump;
    logic          ex_reg_write, ex_mem_read, ex_is_mc;
    logic          mem_reg_write, wb_reg_write;
    logic          branch_taken, mc_done, perf_clr;
    logic [1:0]    fwd_a, fwd_b;
    logic          stall_pc, stall_if_id, hold_id_ex, bubble_id_ex;
    logic          bubble_ex_mem, flush_if_id, flush_id_ex, flush_ex_mem;
    logic          mc_start, mc_abort, mc_timeout;
    logic [CW-1:0] perf_load_use, perf_mc_stall, perf_flush;

    int checks   = 0;
    int failures = 0;

    mips_hazard_unit #(
        .REG_ADDR_W  (RW),
        .BRANCH_STAGE(BS),
        .MC_TIMEOUT  (TO),
        .CNT_W       (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .id_jump      (id_jump),
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .ex_wr_reg    (ex_wr_reg),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .ex_is_mc     (ex_is_mc),
        .mem_wr_reg   (mem_wr_reg),
        .mem_reg_write(mem_reg_write),
        .wb_wr_reg    (wb_wr_reg),
        .wb_reg_write (wb_reg_write),
        .branch_taken (branch_taken),
        .mc_done      (mc_done),
        .perf_clr     (perf_clr),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .stall_pc     (stall_pc),
        .stall_if_id  (stall_if_id),
        .hold_id_ex   (hold_id_ex),
        .bubble_id_ex (bubble_id_ex),
        .bubble_ex_mem(bubble_ex_mem),
        .flush_if_id  (flush_if_id),
        .flush_id_ex  (flush_id_ex),
        .flush_ex_mem (flush_ex_mem),
        .mc_start     (mc_start),
        .mc_abort     (mc_abort),
        .mc_timeout   (mc_timeout),
        .perf_load_use(perf_load_use),
        .perf_mc_stall(perf_mc_stall),
        .perf_flush   (perf_flush)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [63:0] act,
                                logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    // Model state: whether an mc op is outstanding, which busy cycle
    // (1-based) we are in, the sticky timeout flag and the event counts.
    bit m_busy;
    int m_bcyc;
    bit m_sticky;
    int m_plu, m_pmc, m_pfl;

    typedef struct packed {
        logic [1:0] fa;
        logic [1:0] fb;
        logic spc, sif, hold, bie, bem;
        logic fif, fie, fem;
        logic start, abort, set_to, nbusy;
        logic ev_lu, ev_mc, ev_fl;
    } exp_t;

    // Which pipeline stage supplies a source register: scan producers
    // from youngest (MEM) to oldest (WB); r0 never forwards.
    function automatic logic [1:0] src_of(logic [RW-1:0] r);
        if (r == 0) return 2'b00;
        if (mem_reg_write && mem_wr_reg == r) return 2'b10;
        if (wb_reg_write && wb_wr_reg == r) return 2'b01;
        return 2'b00;
    endfunction

    function automatic exp_t predict();
        exp_t e;
        bit   load_hz, waiting, done_now, timed_out;
        e = '0;
        e.nbusy = m_busy;
        if (!reset) return e;
        e.fa = src_of(ex_rs);
        e.fb = src_of(ex_rt);
        load_hz = ex_mem_read && ex_wr_reg != 0 &&
                  ((id_uses_rs && id_rs == ex_wr_reg) ||
                   (id_uses_rt && id_rt == ex_wr_reg));
        done_now  = m_busy && mc_done;
        waiting   = ex_is_mc && !done_now;
        timed_out = m_busy && !mc_done && m_bcyc == TO;
        if (branch_taken) begin
            e.fif = 1; e.fie = 1; e.fem = (BS == 1);
            e.ev_fl = 1;
            if (m_busy && BS == 1) begin
                e.abort = 1;
                e.nbusy = 0;
            end
            return e;
        end
        if (!m_busy && ex_is_mc) begin
            e.start = 1;
            e.nbusy = 1;
        end
        if (done_now) e.nbusy = 0;
        if (timed_out) begin
            e.abort = 1; e.set_to = 1; e.bem = 1; e.nbusy = 0;
        end
        if (waiting) begin
            {e.spc, e.sif, e.hold, e.bem} = 4'b1111;
            e.ev_mc = 1;
        end else if (load_hz) begin
            {e.spc, e.sif, e.bie} = 3'b111;
            e.ev_lu = 1;
        end else if (id_jump) begin
            e.fif = 1;
            e.ev_fl = 1;
        end
        return e;
    endfunction

    function automatic int bump(int c, logic ev);
        if (perf_clr) return 0;
        if (ev && c < CMAX) return c + 1;
        return c;
    endfunction

    always @(posedge clk or negedge reset) begin
        exp_t e;
        if (!reset) begin
            m_busy = 0; m_bcyc = 0; m_sticky = 0;
            m_plu = 0; m_pmc = 0; m_pfl = 0;
        end else begin
            e = predict();
            if (e.set_to) m_sticky = 1;
            m_bcyc = e.nbusy ? m_bcyc + 1 : 0;
            m_busy = e.nbusy;
            m_plu  = bump(m_plu, e.ev_lu);
            m_pmc  = bump(m_pmc, e.ev_mc);
            m_pfl  = bump(m_pfl, e.ev_fl);
        end
    end

    // Compare every cycle, away from the active edge
    bit chk_en = 0;
    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            e = predict();
            chk("m.fwd_a", fwd_a, e.fa);
            chk("m.fwd_b", fwd_b, e.fb);
            chk("m.stall_pc", stall_pc, e.spc);
            chk("m.stall_if_id", stall_if_id, e.sif);
            chk("m.hold_id_ex", hold_id_ex, e.hold);
            chk("m.bubble_id_ex", bubble_id_ex, e.bie);
            chk("m.bubble_ex_mem", bubble_ex_mem, e.bem);
            chk("m.flush_if_id", flush_if_id, e.fif);
            chk("m.flush_id_ex", flush_id_ex, e.fie);
            chk("m.flush_ex_mem", flush_ex_mem, e.fem);
            chk("m.mc_start", mc_start, e.start);
            chk("m.mc_abort", mc_abort, e.abort);
            chk("m.mc_timeout", mc_timeout, m_sticky);
            chk("m.perf_load_use", perf_load_use, m_plu);
            chk("m.perf_mc_stall", perf_mc_stall, m_pmc);
            chk("m.perf_flush", perf_flush, m_pfl);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        {id_rs, id_rt, ex_rs, ex_rt, ex_wr_reg} = '0;
        {mem_wr_reg, wb_wr_reg} = '0;
        {id_uses_rs, id_uses_rt, id_jump} = '0;
        {ex_reg_write, ex_mem_read, ex_is_mc} = '0;
        {mem_reg_write, wb_reg_write} = '0;
        {branch_taken, mc_done, perf_clr} = '0;
    endtask

    initial begin
        reset = 1'b0;
        clear_in();
        chk_en = 1;
        repeat (2) @(negedge clk);
        chk("rst.perf_flush", perf_flush, 0);
        chk("rst.mc_timeout", mc_timeout, 0);
        adv();
        reset = 1'b1;

        // forwarding: MEM only, MEM+WB, r0, WB only
        ex_rs = 1; ex_rt = 3; mem_wr_reg = 1; mem_reg_write = 1;
        @(negedge clk);
        chk("fwd.mem", fwd_a, 2'b10);
        chk("fwd.nostall", stall_pc, 0);
        adv();
        wb_wr_reg = 1; wb_reg_write = 1;
        @(negedge clk);
        chk("fwd.mem_over_wb", fwd_a, 2'b10);
        adv();
        mem_wr_reg = 0; wb_wr_reg = 0; ex_rs = 0;
        @(negedge clk);
        chk("fwd.r0", fwd_a, 2'b00);
        adv();
        mem_reg_write = 0; wb_wr_reg = 3;
        @(negedge clk);
        chk("fwd.wb_b", fwd_b, 2'b01);
        adv();
        clear_in();

        // load-use: lw $4 then a reader of rt=4
        ex_mem_read = 1; ex_wr_reg = 4; id_uses_rt = 1; id_rt = 4;
        @(negedge clk);
        chk("lu.stall", stall_pc, 1);
        chk("lu.bubble", bubble_id_ex, 1);
        adv();
        ex_mem_read = 0; ex_wr_reg = 0;
        @(negedge clk);
        chk("lu.released", stall_pc, 0);
        chk("lu.count", perf_load_use, 1);
        adv();
        clear_in();

        // mul with mc_done five cycles after mc_start
        ex_is_mc = 1;
        @(negedge clk);
        chk("mc.start", mc_start, 1);
        adv();
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            chk("mc.wait", stall_pc, 1);
            adv();
        end
        mc_done = 1;
        @(negedge clk);
        chk("mc.done_release", stall_pc, 0);
        adv();
        clear_in();
        @(negedge clk);
        chk("mc.count", perf_mc_stall, 5);
        adv();

        // MEM-resolved branch while busy
        ex_is_mc = 1;
        adv();
        adv();
        branch_taken = 1;
        @(negedge clk);
        chk("br.flush_ex_mem", flush_ex_mem, 1);
        chk("br.abort", mc_abort, 1);
        chk("br.nostall", stall_pc, 0);
        adv();
        clear_in();
        @(negedge clk);
        chk("br.no_timeout", mc_timeout, 0);
        adv();

        // jump alone, then jump under a load-use stall
        id_jump = 1;
        @(negedge clk);
        chk("jmp.flush", flush_if_id, 1);
        adv();
        ex_mem_read = 1; ex_wr_reg = 2; id_uses_rs = 1; id_rs = 2;
        @(negedge clk);
        chk("jmp.lu_wins", flush_if_id, 0);
        adv();
        clear_in();

        // timeout: abort lands on the TO-th busy cycle
        ex_is_mc = 1;
        for (int i = 0; i <= TO; i++) begin
            @(negedge clk);
            chk("to.abort", mc_abort, (i == TO) ? 1 : 0);
            adv();
        end
        clear_in();
        repeat (3) adv();
        @(negedge clk);
        chk("to.sticky", mc_timeout, 1);
        adv();

        // clear beats a same-cycle event
        perf_clr = 1; id_jump = 1;
        adv();
        clear_in();
        @(negedge clk);
        chk("clr.flush", perf_flush, 0);
        adv();

        // saturation of perf_flush
        branch_taken = 1;
        repeat (20) adv();
        branch_taken = 0;
        @(negedge clk);
        chk("sat.flush", perf_flush, CMAX);
        adv();

        // asynchronous reset in the middle of a busy op
        ex_is_mc = 1;
        adv();
        adv();
        #2 reset = 1'b0;
        #1;
        chk("arst.stall", stall_pc, 0);
        chk("arst.start", mc_start, 0);
        chk("arst.flush_cnt", perf_flush, 0);
        chk("arst.timeout", mc_timeout, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("arst.restart", mc_start, 1);
        adv();
        clear_in();
        adv();

        @(negedge clk);
        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
